// File: rtl/spi_reg_arbiter_if.sv
// Bundle of SPI-frame, host-port and status signals around the register arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface spi_reg_arbiter_if #(
  parameter int unsigned addrsz  = 7,
  parameter int unsigned payload = 8
);
  logic               spi_active;
  logic [addrsz-1:0]  spi_addr;
  logic               spi_addr_dv;
  logic               spi_rw;
  logic [payload-1:0] spi_rx_d;
  logic               spi_rxdv;
  logic [payload-1:0] spi_tx_d;
  logic               host_req;
  logic               host_we;
  logic [addrsz-1:0]  host_addr;
  logic [payload-1:0] host_wdata;
  logic               host_gnt;
  logic [payload-1:0] host_rdata;
  logic               host_rvalid;
  logic               reg_wr_pulse;
  logic [addrsz-1:0]  reg_wr_addr;
  logic               spi_err;
  logic [7:0]         err_cnt;
  logic               err_cnt_clr;

  modport slave (
    input  spi_active, spi_addr, spi_addr_dv, spi_rw, spi_rx_d, spi_rxdv,
    input  host_req, host_we, host_addr, host_wdata, err_cnt_clr,
    output spi_tx_d, host_gnt, host_rdata, host_rvalid,
    output reg_wr_pulse, reg_wr_addr, spi_err, err_cnt
  );

  modport master (
    output spi_active, spi_addr, spi_addr_dv, spi_rw, spi_rx_d, spi_rxdv,
    output host_req, host_we, host_addr, host_wdata, err_cnt_clr,
    input  spi_tx_d, host_gnt, host_rdata, host_rvalid,
    input  reg_wr_pulse, reg_wr_addr, spi_err, err_cnt
  );
endinterface

// File: rtl/spi_reg_arbiter.sv
// Register bank shared between SPI frame accesses and a local host port.
// One array access per cycle; priority is SPI write > SPI read > host.
module spi_reg_arbiter #(
  parameter int unsigned      addrsz  = 7,
  parameter int unsigned      payload = 8,
  parameter int unsigned      nregs   = 32,
  parameter logic [nregs-1:0] ro_mask = '0
) (
  input logic              clk,
  input logic              reset,
  spi_reg_arbiter_if.slave bus
);
  localparam int unsigned       idx_w     = (nregs > 1) ? $clog2(nregs) : 1;
  localparam logic [addrsz:0]   nregs_lim = (addrsz + 1)'(nregs);

  localparam logic [2:0] F_IDLE  = 3'd0;
  localparam logic [2:0] F_ADDR  = 3'd1;
  localparam logic [2:0] F_READ  = 3'd2;
  localparam logic [2:0] F_WRITE = 3'd3;
  localparam logic [2:0] F_DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [addrsz-1:0]  addr_q, addr_d;
  logic [payload-1:0] wdata_q, wdata_d;
  logic               rd_pend_q, rd_pend_d;
  logic               wr_pend_q, wr_pend_d;
  logic               active_q, addr_dv_q, rxdv_q;
  logic [payload-1:0] regs_q [nregs];
  logic [payload-1:0] tx_q, host_rdata_q;
  logic               host_rvalid_q, wr_pulse_q, err_q;
  logic [addrsz-1:0]  wr_addr_q;
  logic [7:0]         err_cnt_q;

  logic               active_rise, addr_rise, rxdv_rise, abort_err;
  logic               rd_go, host_go, spi_commit, err_d;
  logic               spi_addr_ok, host_addr_ok, ro_hit;
  logic [idx_w-1:0]   spi_idx, host_idx, widx;
  logic               we;
  logic [payload-1:0] wdat;

  assign active_rise  = bus.spi_active & ~active_q;
  assign addr_rise    = bus.spi_addr_dv & ~addr_dv_q;
  assign rxdv_rise    = bus.spi_rxdv & ~rxdv_q;

  assign spi_addr_ok  = {1'b0, addr_q} < nregs_lim;
  assign host_addr_ok = {1'b0, bus.host_addr} < nregs_lim;
  assign spi_idx      = addr_q[idx_w-1:0];
  assign host_idx     = bus.host_addr[idx_w-1:0];
  assign ro_hit       = ro_mask[spi_idx];

  // A read whose frame has already ended is dropped rather than serviced.
  assign rd_go      = rd_pend_q & ~wr_pend_q & bus.spi_active;
  assign host_go    = bus.host_req & ~wr_pend_q & ~rd_pend_q & ~reset;
  assign spi_commit = wr_pend_q & spi_addr_ok & ~ro_hit;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_pend_d = rd_pend_q & ~rd_go;
    wr_pend_d = 1'b0;
    abort_err = 1'b0;
    case (state_q)
      F_IDLE: if (active_rise) state_d = F_ADDR;
      F_ADDR: begin
        if (!bus.spi_active) begin
          state_d   = F_IDLE;
          abort_err = 1'b1;
        end else if (addr_rise) begin
          addr_d = bus.spi_addr;
          if (bus.spi_rw) begin
            state_d   = F_READ;
            rd_pend_d = 1'b1;
          end else begin
            state_d = F_WRITE;
          end
        end
      end
      F_WRITE: begin
        if (!bus.spi_active) begin
          state_d   = F_IDLE;
          abort_err = 1'b1;
        end else if (rxdv_rise) begin
          wdata_d   = bus.spi_rx_d;
          wr_pend_d = 1'b1;
          state_d   = F_DONE;
        end
      end
      F_READ: begin
        if (!bus.spi_active) begin
          state_d   = F_IDLE;
          rd_pend_d = 1'b0;
        end else if (rd_go) begin
          state_d = F_DONE;
        end
      end
      F_DONE:  if (!bus.spi_active) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    we   = 1'b0;
    widx = spi_idx;
    wdat = wdata_q;
    if (spi_commit) begin
      we = 1'b1;
    end else if (host_go && bus.host_we && host_addr_ok) begin
      we   = 1'b1;
      widx = host_idx;
      wdat = bus.host_wdata;
    end
    err_d = abort_err | (wr_pend_q & ~spi_commit) | (rd_go & ~spi_addr_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= F_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_pend_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      active_q      <= 1'b0;
      addr_dv_q     <= 1'b0;
      rxdv_q        <= 1'b0;
      regs_q        <= '{default: '0};
      tx_q          <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      wr_pulse_q    <= 1'b0;
      wr_addr_q     <= '0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_pend_q     <= rd_pend_d;
      wr_pend_q     <= wr_pend_d;
      active_q      <= bus.spi_active;
      addr_dv_q     <= bus.spi_addr_dv;
      rxdv_q        <= bus.spi_rxdv;
      if (we) regs_q[widx] <= wdat;
      if (rd_go) tx_q <= spi_addr_ok ? regs_q[spi_idx] : '0;
      host_rvalid_q <= host_go & ~bus.host_we;
      if (host_go && !bus.host_we) host_rdata_q <= host_addr_ok ? regs_q[host_idx] : '0;
      wr_pulse_q    <= spi_commit;
      if (spi_commit) wr_addr_q <= addr_q;
      err_q         <= err_d;
      // A clear coinciding with an error leaves that error counted.
      if (bus.err_cnt_clr) err_cnt_q <= {7'd0, err_q};
      else if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.spi_tx_d     = tx_q;
  assign bus.host_gnt     = host_go;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.reg_wr_pulse = wr_pulse_q;
  assign bus.reg_wr_addr  = wr_addr_q;
  assign bus.spi_err      = err_q;
  assign bus.err_cnt      = err_cnt_q;
endmodule

// File: doc/spi_reg_arbiter.md
Name: spi_reg_arbiter

Overview:
Register-bank controller behind spi_slave. It owns a single-port register array and shares it between two requesters: the SPI side (address, write data and read data from the slave's decoded frame outputs) and a local host port. It sequences each SPI frame through an address/read/write FSM and presents read data on spi_tx_d in time for MISO. SPI accesses have fixed priority over host accesses.

Parameters:
addrsz, 7, SPI/host address width
payload, 8, register data width
nregs, 32, implemented registers (1..2**addrsz); addresses >= nregs are invalid
ro_mask, 0, nregs-bit mask; bit i=1 makes register i read-only from SPI (host may always write)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
spi_active  in  1  frame in progress (synchronized ~SSB), level
spi_addr  in  addrsz  decoded address from slave
spi_addr_dv  in  1  address valid, level, held for rest of frame
spi_rw  in  1  1=read, 0=write; valid while spi_addr_dv high
spi_rx_d  in  payload  write data from master
spi_rxdv  in  1  write data valid, level
spi_tx_d  out  payload  read data to slave (MISO source)
host_req  in  1  host access request, held until host_gnt
host_we  in  1  1=write
host_addr  in  addrsz  host address
host_wdata  in  payload  host write data
host_gnt  out  1  one-cycle grant; access executes this cycle
host_rdata  out  payload  host read data
host_rvalid  out  1  one-cycle pulse, cycle after a granted read
reg_wr_pulse  out  1  one-cycle pulse on each committed SPI write
reg_wr_addr  out  addrsz  address of that write
spi_err  out  1  one-cycle pulse: invalid address, RO write, or aborted frame
err_cnt  out  8  saturating count of spi_err pulses
err_cnt_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset (async, any time including mid-frame): all registers 0, FSM F_IDLE, pending flags cleared, all outputs 0.
- Rising-edge detect on spi_addr_dv and spi_rxdv against a registered copy; levels held high cause no re-trigger.
- Frame FSM: F_IDLE -> F_ADDR when spi_active rises. F_ADDR -> F_READ on addr_dv rise with spi_rw=1 (latch addr, set rd_pend); F_ADDR -> F_WRITE on addr_dv rise with spi_rw=0 (latch addr). F_WRITE -> F_DONE on rxdv rise (set wr_pend). F_READ -> F_DONE after read serviced. F_DONE -> F_IDLE on spi_active low.
- Abort: spi_active falls in F_ADDR or F_WRITE -> F_IDLE, no register write, spi_err pulse. Falling in F_READ with rd_pend still set -> discard read, no error.
- Arbitration, one array access per cycle: priority wr_pend > rd_pend > host_req. A pending flag is serviced the cycle after it is set; host_gnt is withheld that cycle. The host request stays pending and is granted on the next free cycle. Max host stall is 1 cycle per SPI event.
- SPI read latency: addr_dv rise seen in cycle 0 -> serviced cycle 1 -> spi_tx_d valid from cycle 2. It holds until the next SPI read, then drives 0 after reset.
- Invalid SPI read address (>= nregs): spi_tx_d <= 0, spi_err pulse.
- SPI write commit: array updated at end of service cycle. reg_wr_pulse/reg_wr_addr are asserted in the cycle after. Invalid address or RO register: no update, no reg_wr_pulse, spi_err pulse.
- Host: write updates the array at end of the grant cycle. Read returns host_rdata with host_rvalid on the next cycle; host_rdata holds until the next read. Invalid host address: write ignored, read returns 0; spi_err is not asserted.
- Same-address collision: SPI write serviced first, host write next cycle, so the host value is final. A host read after an SPI write returns the SPI value.
- err_cnt: +1 per spi_err, saturates at 255. If err_cnt_clr and spi_err occur in the same cycle, err_cnt becomes 1.

Test Plan:
- SPI write addr 0x05 data 0xA5, then SPI read addr 0x05 -> reg_wr_pulse with reg_wr_addr=0x05; spi_tx_d=0xA5 two cycles after addr_dv rise.
- host_req write 0x03=0x3C held in the same cycle as SPI wr_pend to 0x03=0x11 -> host_gnt delayed 1 cycle; host read 0x03 returns 0x3C with host_rvalid.
- ro_mask bit 2 set, SPI write 0x02=0xFF -> reg unchanged, no reg_wr_pulse, spi_err, err_cnt=1; host write 0x02=0xFF succeeds.
- SPI read addr 0x40 (nregs=32) -> spi_tx_d=0x00, spi_err; SPI write frame with spi_active dropped before rxdv -> no write, spi_err.
- 260 forced errors -> err_cnt=255; err_cnt_clr with a simultaneous error -> err_cnt=1.
- reset asserted in F_WRITE after rxdv rise, before commit -> register stays 0, all outputs 0, FSM F_IDLE; next frame works normally.
